feature_frame_sequencer: RTL and testbench
==========================================

# feature_frame_sequencer

Upstream acquisition stage for the printed-MLP classifiers: drives a shared multiplexed ADC across the sensor channels one at a time, quantizes each conversion to the classifier's feature width, and packs the results into the flat feature vector consumed by the combinational `top` classifier. It also presents a stable, valid-qualified frame so the classifier input never changes mid-evaluation.

## Interface
- `N_FEAT`, 6: number of features/channels per frame
- `ADC_W`, 8: ADC result width
- `FEAT_W`, 4: quantized feature width; must satisfy FEAT_W < ADC_W
- `SETTLE_CYC`, 2: mux settling cycles before each conversion; 0 allowed
- `TIMEOUT_CYC`, 64: max WAIT cycles per conversion before timeout
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request a new frame; sampled only in IDLE and DONE
- `adc_sel`  out  $clog2(N_FEAT)  analog channel select
- `adc_conv`  out  1  one-cycle conversion-start pulse
- `adc_done`  in  1  conversion complete; `adc_data` valid this cycle
- `adc_data`  in  ADC_W  raw conversion result
- `frame`  out  N_FEAT*FEAT_W  packed features; feature i at [i*FEAT_W +: FEAT_W]; connects to classifier `inp`
- `frame_valid`  out  1  frame complete, held until accepted
- `frame_ready`  in  1  consumer accepts frame
- `busy`  out  1  high in every state except IDLE
- `err`  out  1  sticky: at least one conversion of the current/last frame timed out

## Operation
- States: IDLE, SETTLE, CONV, WAIT, DONE.
- IDLE: `start` -> ch=0, reset shadow buffer, clear `err`; go SETTLE (or CONV if SETTLE_CYC=0).
- SETTLE: `adc_sel`=ch; stay exactly SETTLE_CYC cycles -> CONV.
- CONV: `adc_conv`=1 for exactly one cycle -> WAIT.
- WAIT: on `adc_done`, write quantized `adc_data` into shadow slot ch. If timeout counter reaches TIMEOUT_CYC first: write 0 into slot ch, set `err`. Then, if ch==N_FEAT-1 -> DONE; else ch+1 -> SETTLE/CONV.
- DONE entry: shadow copied to `frame` register in the same edge as state change; `frame_valid`=1.
- DONE: `frame_ready` & `start` -> directly to new acquisition (as IDLE+start, same cycle); `frame_ready` alone -> IDLE; otherwise hold.
- `frame` changes only on DONE entry; holds last value during acquisition and in IDLE.
- `adc_done` outside WAIT ignored. `start` outside IDLE/DONE ignored.
- Default quantization: truncation, feat = adc_data[ADC_W-1 -: FEAT_W].
- Reset: state IDLE, ch=0, `adc_sel`=0, `adc_conv`=0, `frame`=0, `frame_valid`=0, `busy`=0, `err`=0, counters 0. Reset mid-acquisition discards shadow contents.

## Timing
- Per channel: SETTLE_CYC + 1 + D cycles, D ≥ 1 = WAIT cycles up to and including `adc_done`.
- `start` sampled in cycle T -> `frame_valid` first high at T + 1 + N_FEAT*(SETTLE_CYC+1+D) - 1 + 1; with defaults and D=1: cycle T+25.
- `adc_done` coincident with the timeout cycle: data wins, no `err`.
- `adc_sel` stable from first SETTLE cycle through the WAIT exit of that channel.
- `frame_valid` deasserts the cycle after `frame_ready` handshake.

## Configuration
- `FEAT_ROUND_EN` defined: round-to-nearest with saturation: feat = min((adc_data + 2^(ADC_W-FEAT_W-1)) >> (ADC_W-FEAT_W), 2^FEAT_W-1), sum computed ADC_W+1 bits wide.
- Undefined: plain truncation as above; no adder instantiated.

## Structure
- Shared package `ffs_pkg`: state enum, default parameter constants, packed-slot index helper.
- One sub-module `feat_quant` (purely combinational ADC_W -> FEAT_W quantizer, containing the `FEAT_ROUND_EN` branch).

## Test plan
- Defaults, `adc_done` 1 cycle after each `adc_conv`, data 0x10,0x20,...,0x60 -> `frame`=24'h654321, `frame_valid` at T+25, `adc_sel` steps 0..5.
- `adc_data`=0x17 then 0x18, 0xF8 -> truncation gives 1,1,15; with `FEAT_ROUND_EN` gives 1,2,15 (saturation).
- Channel 3 never gets `adc_done` -> after 64 WAIT cycles slot 3=0, `err`=1, frame completes; next `start` clears `err`.
- `frame_ready` held low 10 cycles in DONE -> `frame` and `frame_valid` stable; then `frame_ready`&`start` same cycle -> `busy` stays 1, next frame starts immediately, old `frame` retained until new DONE.
- `rst` asserted in WAIT of channel 2 -> all outputs to reset values asynchronously; spurious `adc_done` in IDLE -> no state change.

Source files
------------

// File: rtl/ffs_pkg.sv
// ffs_pkg: shared types and constants for the feature frame sequencer.
// Holds the FSM state encoding, default parameter values and small
// helpers for slot indexing and channel-select width.
package ffs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONV,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int DEF_N_FEAT      = 6;
    localparam int DEF_ADC_W       = 8;
    localparam int DEF_FEAT_W      = 4;
    localparam int DEF_SETTLE_CYC  = 2;
    localparam int DEF_TIMEOUT_CYC = 64;

    // LSB position of feature slot idx inside the packed frame.
    function automatic int slot_lsb(input int idx, input int feat_w);
        return idx * feat_w;
    endfunction

    // Width of the channel select; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feature_frame_sequencer_if.sv
// feature_frame_sequencer_if: ADC control bus plus frame handshake.
// master = sequencer side, slave = ADC / classifier / controller side.
interface feature_frame_sequencer_if #(
    parameter int N_FEAT = 6,
    parameter int ADC_W  = 8,
    parameter int FEAT_W = 4
) ();
    localparam int SEL_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    logic                     start;
    logic [SEL_W-1:0]         adc_sel;
    logic                     adc_conv;
    logic                     adc_done;
    logic [ADC_W-1:0]         adc_data;
    logic [N_FEAT*FEAT_W-1:0] frame;
    logic                     frame_valid;
    logic                     frame_ready;
    logic                     busy;
    logic                     err;

    modport master (
        input  start, adc_done, adc_data, frame_ready,
        output adc_sel, adc_conv, frame, frame_valid, busy, err
    );

    modport slave (
        output start, adc_done, adc_data, frame_ready,
        input  adc_sel, adc_conv, frame, frame_valid, busy, err
    );
endinterface

// File: rtl/feat_quant.sv
// feat_quant: combinational ADC_W -> FEAT_W feature quantizer.
// Default: truncation to the top FEAT_W bits.
// Define FEAT_ROUND_EN for round-to-nearest with saturation at the
// maximum code; the rounding sum is ADC_W+1 bits so it cannot wrap.
module feat_quant #(
    parameter int ADC_W  = 8,
    parameter int FEAT_W = 4
) (
    input  logic [ADC_W-1:0]  adc_data,
    output logic [FEAT_W-1:0] feat
);
    localparam int SHIFT = ADC_W - FEAT_W;

`ifdef FEAT_ROUND_EN
    localparam logic [ADC_W:0] HALF    = (ADC_W+1)'(1) << (SHIFT - 1);
    localparam logic [ADC_W:0] MAX_VAL = (ADC_W+1)'((1 << FEAT_W) - 1);

    logic [ADC_W:0] sum_ext;
    logic [ADC_W:0] shifted;

    // Add half an output LSB, drop the fraction, clamp to the top code.
    always_comb begin
        sum_ext = {1'b0, adc_data} + HALF;
        shifted = sum_ext >> SHIFT;
        feat    = (shifted > MAX_VAL) ? '1 : shifted[FEAT_W-1:0];
    end
`else
    // Low bits are discarded by truncation.
    logic unused_lsbs;
    assign unused_lsbs = ^adc_data[SHIFT-1:0];

    assign feat = adc_data[ADC_W-1 -: FEAT_W];
`endif

endmodule

// File: rtl/feature_frame_sequencer.sv
// feature_frame_sequencer: scans N_FEAT channels through a shared ADC,
// quantizes each result and publishes a stable, valid-qualified frame.
// Optional rounding quantizer: define FEAT_ROUND_EN (see feat_quant).
module feature_frame_sequencer
    import ffs_pkg::*;
#(
    parameter int N_FEAT      = DEF_N_FEAT,
    parameter int ADC_W       = DEF_ADC_W,
    parameter int FEAT_W      = DEF_FEAT_W,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic clk,
    input logic rst,
    feature_frame_sequencer_if.master bus
);
    localparam int     SEL_W    = sel_width(N_FEAT);
    localparam int     FRAME_W  = N_FEAT * FEAT_W;
    localparam int     CNT_MAX  = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int     CNT_W    = $clog2(CNT_MAX + 1);
    localparam state_t FIRST_ST = (SETTLE_CYC == 0) ? ST_CONV : ST_SETTLE;

    state_t             state_q,       state_d;
    logic [SEL_W-1:0]   ch_q,          ch_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [FRAME_W-1:0] shadow_q,      shadow_d;
    logic [FRAME_W-1:0] frame_q,       frame_d;
    logic               err_q,         err_d;
    logic               adc_conv_q,    adc_conv_d;
    logic               frame_valid_q, frame_valid_d;
    logic               busy_q,        busy_d;

    logic [FEAT_W-1:0]  q_feat;
    logic [FEAT_W-1:0]  slot_val;
    logic               launch;
    logic               timed_out;

    feat_quant #(
        .ADC_W  (ADC_W),
        .FEAT_W (FEAT_W)
    ) u_quant (
        .adc_data (bus.adc_data),
        .feat     (q_feat)
    );

    // Next-state, slot write and registered-output computation.
    always_comb begin
        // NOTE: every variable gets a default here so no path infers a latch.
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        frame_d   = frame_q;
        err_d     = err_q;
        slot_val  = '0;
        launch    = 1'b0;
        timed_out = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) launch = 1'b1;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = ST_CONV;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CONV: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (bus.adc_done || timed_out) begin
                    // Data on the timeout cycle still wins over the timeout.
                    slot_val = bus.adc_done ? q_feat : '0;
                    if (!bus.adc_done) err_d = 1'b1;
                    shadow_d[slot_lsb(int'(ch_q), FEAT_W) +: FEAT_W] = slot_val;
                    cnt_d = '0;
                    if (ch_q == SEL_W'(N_FEAT - 1)) begin
                        state_d = ST_DONE;
                        frame_d = shadow_d;
                    end else begin
                        ch_d    = ch_q + SEL_W'(1);
                        state_d = FIRST_ST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.frame_ready) begin
                    if (bus.start) launch  = 1'b1;
                    else           state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            state_d  = FIRST_ST;
            ch_d     = '0;
            cnt_d    = '0;
            shadow_d = '0;
            err_d    = 1'b0;
        end

        adc_conv_d    = (state_d == ST_CONV);
        frame_valid_d = (state_d == ST_DONE);
        busy_d        = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ch_q          <= '0;
            cnt_q         <= '0;
            // NOTE: the shadow buffer is small flop storage, so it is reset
            // too; a reset mid-acquisition then leaves no stale features.
            shadow_q      <= '0;
            frame_q       <= '0;
            err_q         <= 1'b0;
            adc_conv_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers update from pre-edge values.
            state_q       <= state_d;
            ch_q          <= ch_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            err_q         <= err_d;
            adc_conv_q    <= adc_conv_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.adc_sel     = ch_q;
    assign bus.adc_conv    = adc_conv_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_feature_frame_sequencer.sv
// tb_feature_frame_sequencer: directed + randomized bench with an ADC
// responder and a frame-level reference model (latency, packed frame, err).
module tb_feature_frame_sequencer;
    localparam int N_FEAT      = 6;
    localparam int ADC_W       = 8;
    localparam int FEAT_W      = 4;
    localparam int SETTLE_CYC  = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int FRAME_W     = N_FEAT * FEAT_W;
    localparam int BUDGET      = 1000;

    logic clk;
    logic rst;

    feature_frame_sequencer_if #(
        .N_FEAT (N_FEAT),
        .ADC_W  (ADC_W),
        .FEAT_W (FEAT_W)
    ) bus ();

    feature_frame_sequencer #(
        .N_FEAT      (N_FEAT),
        .ADC_W       (ADC_W),
        .FEAT_W      (FEAT_W),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-channel stimulus: raw data and response delay (0 = never answers).
    int dat [8];
    int dly [8];
    logic [FRAME_W-1:0] mdl_frame;

    // ADC responder: raises adc_done dly cycles after the conversion pulse.
    logic             resp_done;
    logic             spur_done;
    logic [ADC_W-1:0] adc_data_drv;
    int               pend;
    int               cnt;
    int               pch;

    assign bus.adc_done = resp_done | spur_done;
    assign bus.adc_data = adc_data_drv;

    always @(negedge clk) begin
        resp_done    = 1'b0;
        adc_data_drv = ADC_W'($urandom);
        if (rst) begin
            pend = 0;
        end else begin
            if (pend != 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    resp_done    = 1'b1;
                    adc_data_drv = ADC_W'(dat[pch]);
                    pend         = 0;
                end
            end
            if (bus.adc_conv) begin
                pch = int'(bus.adc_sel);
                if (dly[pch] != 0) begin
                    pend = 1;
                    cnt  = dly[pch];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FEAT_W-1:0] q_ref(input int d);
        int r;
`ifdef FEAT_ROUND_EN
        r = (d + (1 << (ADC_W - FEAT_W - 1))) / (1 << (ADC_W - FEAT_W));
        if (r > (1 << FEAT_W) - 1) r = (1 << FEAT_W) - 1;
`else
        r = d / (1 << (ADC_W - FEAT_W));
`endif
        return FEAT_W'(r);
    endfunction

    task automatic randomize_frame(input int max_dly);
        for (int i = 0; i < N_FEAT; i++) begin
            dat[i] = int'($urandom_range(0, (1 << ADC_W) - 1));
            dly[i] = int'($urandom_range(1, max_dly));
        end
    endtask

    // Start one frame (optionally with frame_ready in the same cycle) and
    // compare latency, frame contents, err and channel order to the model.
    task automatic acquire(input bit with_ready, input string tag);
        logic [FRAME_W-1:0] exp_frame;
        int  exp_lat;
        bit  exp_err;
        int  lat;
        bit  stable_ok;
        int  sels[$];

        exp_frame = '0;
        exp_lat   = 1;
        exp_err   = 1'b0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (dly[i] == 0) begin
                exp_err = 1'b1;
                exp_lat += SETTLE_CYC + 1 + TIMEOUT_CYC;
            end else begin
                exp_frame[i*FEAT_W +: FEAT_W] = q_ref(dat[i]);
                exp_lat += SETTLE_CYC + 1 + dly[i];
            end
        end

        @(negedge clk);
        bus.start       = 1'b1;
        bus.frame_ready = with_ready;
        lat       = 0;
        stable_ok = 1'b1;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start       = 1'b0;
                bus.frame_ready = 1'b0;
                check({tag, " busy after start"}, 64'(bus.busy), 64'd1);
                check({tag, " err cleared by start"}, 64'(bus.err), 64'd0);
            end
            if (bus.adc_conv) sels.push_back(int'(bus.adc_sel));
            if (bus.frame_valid) begin
                lat = k;
                break;
            end
            if (bus.frame !== mdl_frame || bus.busy !== 1'b1) stable_ok = 1'b0;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " frame"}, 64'(bus.frame), 64'(exp_frame));
        check({tag, " err"}, 64'(bus.err), 64'(exp_err));
        check({tag, " frame held during acquisition"}, 64'(stable_ok), 64'd1);
        check({tag, " conversions"}, 64'(sels.size()), 64'(N_FEAT));
        for (int i = 0; i < sels.size() && i < N_FEAT; i++)
            check($sformatf("%s adc_sel order %0d", tag, i), 64'(sels[i]), 64'(i));
        mdl_frame = exp_frame;
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        bus.frame_ready = 1'b1;
        @(negedge clk);
        bus.frame_ready = 1'b0;
        check({tag, " valid drops after handshake"}, 64'(bus.frame_valid), 64'd0);
        check({tag, " idle after handshake"}, 64'(bus.busy), 64'd0);
        check({tag, " frame kept in idle"}, 64'(bus.frame), 64'(mdl_frame));
    endtask

    initial begin
        bit hold_ok;
        bit reached;

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.frame_ready = 1'b0;
        spur_done       = 1'b0;
        mdl_frame       = '0;
        for (int i = 0; i < 8; i++) begin
            dat[i] = 0;
            dly[i] = 1;
        end

        repeat (3) @(negedge clk);
        check("reset adc_sel", 64'(bus.adc_sel), 64'd0);
        check("reset adc_conv", 64'(bus.adc_conv), 64'd0);
        check("reset frame", 64'(bus.frame), 64'd0);
        check("reset frame_valid", 64'(bus.frame_valid), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset err", 64'(bus.err), 64'd0);
        rst = 1'b0;

        // Directed ramp: expect 24'h654321 and frame_valid at T+25.
        for (int i = 0; i < N_FEAT; i++) begin
            dat[i] = (i + 1) * 16;
            dly[i] = 1;
        end
        acquire(1'b0, "ramp");
        check("ramp literal frame", 64'(bus.frame), 64'h654321);
        accept("ramp");

        // Quantizer corner values.
        randomize_frame(3);
        dat[0] = 'h17;
        dat[1] = 'h18;
        dat[2] = 'hF8;
        acquire(1'b0, "quant");
        accept("quant");

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            randomize_frame(5);
            acquire(1'b0, $sformatf("rand%0d", f));
            accept($sformatf("rand%0d", f));
        end

        // adc_done on the final timeout cycle: data wins.
        randomize_frame(2);
        dly[2] = TIMEOUT_CYC;
        acquire(1'b0, "edge_timeout");
        accept("edge_timeout");

        // Channel 3 never answers: slot 3 zero, err set.
        randomize_frame(2);
        dly[3] = 0;
        acquire(1'b0, "timeout");

        // Hold in DONE with frame_ready low.
        hold_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.frame_valid !== 1'b1 || bus.frame !== mdl_frame || bus.err !== 1'b1)
                hold_ok = 1'b0;
        end
        check("done hold stable", 64'(hold_ok), 64'd1);

        // frame_ready & start together: straight into the next frame.
        randomize_frame(3);
        acquire(1'b1, "back2back");
        accept("back2back");

        // Reset while waiting on channel 2.
        randomize_frame(2);
        dly[2] = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            if (bus.adc_conv && bus.adc_sel == 2) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached channel 2 conversion", 64'(reached), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset adc_sel", 64'(bus.adc_sel), 64'd0);
        check("async reset adc_conv", 64'(bus.adc_conv), 64'd0);
        check("async reset frame", 64'(bus.frame), 64'd0);
        check("async reset frame_valid", 64'(bus.frame_valid), 64'd0);
        check("async reset busy", 64'(bus.busy), 64'd0);
        check("async reset err", 64'(bus.err), 64'd0);
        mdl_frame = '0;
        @(negedge clk);
        rst = 1'b0;

        // Spurious adc_done while idle must not move the FSM.
        spur_done = 1'b1;
        repeat (3) @(negedge clk);
        spur_done = 1'b0;
        check("spurious done busy", 64'(bus.busy), 64'd0);
        check("spurious done conv", 64'(bus.adc_conv), 64'd0);
        check("spurious done valid", 64'(bus.frame_valid), 64'd0);
        check("spurious done frame", 64'(bus.frame), 64'd0);

        // Normal operation after reset.
        randomize_frame(4);
        acquire(1'b0, "post_reset");
        accept("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
